// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
// Direct-mapped, write-back, write-allocate data cache controller between the MEM
// stage and a 128-bit line memory; stalls the pipeline across write-back and fill.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_data_o,
    input  logic [127:0] mem_data_i,
    input  logic         mem_ack_i
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [127:0]          r_data [LINES];

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [1:0]            w_word;
    logic                  w_hit;
    logic                  w_store_hit;
    logic                  w_wb_done;
    logic                  w_fill_done;
    logic                  w_unused;

    assign w_word      = cpu_addr_i[3:2];
    assign w_index     = cpu_addr_i[INDEX_BITS+3:4];
    assign w_tag       = cpu_addr_i[31:INDEX_BITS+4];
    assign w_unused    = ^cpu_addr_i[1:0];

    assign w_hit       = cpu_req_i && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_store_hit = (r_state == S_IDLE) && w_hit && cpu_we_i;
    assign w_wb_done   = (r_state == S_WRITEBACK) && mem_ack_i;
    assign w_fill_done = (r_state == S_ALLOCATE) && mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cpu_req_i && !w_hit) begin
                    w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: if (mem_ack_i) w_next_state = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Memory-side outputs depend only on state and the held CPU address, so they stay
    // stable for the whole request; the address tracks the victim tag during write-back.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {w_tag, w_index, 4'b0000};
        cpu_stall_o = cpu_req_i && !w_hit;
        case (r_state)
            S_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {r_tag[w_index], w_index, 4'b0000};
                cpu_stall_o = 1'b1;
            end
            S_ALLOCATE: begin
                mem_req_o   = 1'b1;
                cpu_stall_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_data_o = r_data[w_index];
    assign cpu_data_o = r_data[w_index][{w_word, 5'b00000} +: 32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill_done) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_wb_done) begin
            r_dirty[w_index] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bit already masks stale
    // contents, and leaving them unreset lets the arrays map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_fill_done) begin
            r_data[w_index] <= mem_data_i;
            r_tag[w_index]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_index][{w_word, 5'b00000} +: 32] <= cpu_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for dcache_ctrl: directed accesses push expected CPU and memory
// responses; a forked monitor pops and compares when the DUT presents them.
module tb_dcache_ctrl;
    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_data_o;
    logic [127:0] mem_data_i;
    logic         mem_ack_i;

    logic         auto_ack;
    logic         force_ack;
    logic         mem_auto;
    int           ack_delay;
    logic [127:0] mem_store [logic [31:0]];

    assign mem_ack_i = auto_ack | force_ack;

    localparam logic [127:0] L100    = {32'h1111_0003, 32'h1111_0002, 32'hDEAD_BEEF, 32'h1111_0000};
    localparam logic [127:0] L100_WB = {32'h1111_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1111_0000};
    localparam logic [127:0] L200    = {32'h2222_0003, 32'h2222_0002, 32'hCAFE_F00D, 32'h2222_0000};
    localparam logic [127:0] L300    = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    typedef struct {
        logic        we;
        logic [31:0] data;
        int          stalls;
    } cpu_exp_t;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         cont;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    int       n_checks;
    int       n_pass;

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory model: acks the ack_delay-th cycle of each request phase.
    initial begin
        int cnt;
        cnt = 0;
        auto_ack = 1'b0;
        mem_data_i = '0;
        mem_store[32'h0000_0100] = L100;
        mem_store[32'h0000_0200] = L200;
        mem_store[32'h0000_0300] = L300;
        forever begin
            @(negedge clk_i);
            auto_ack = 1'b0;
            if (rst_i || !mem_auto || !mem_req_o) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= ack_delay) begin
                    if (mem_we_o) mem_store[mem_addr_o] = mem_data_o;
                    else mem_data_i = mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o] : '0;
                    auto_ack = 1'b1;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic exp_cpu(input logic we, input logic [31:0] data, input int stalls);
        cpu_exp_t e;
        e.we = we;
        e.data = data;
        e.stalls = stalls;
        cpu_q.push_back(e);
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [127:0] data, input logic cont);
        mem_exp_t e;
        e.we = we;
        e.addr = addr;
        e.data = data;
        e.cont = cont;
        mem_q.push_back(e);
    endtask

    task automatic monitor();
        int       stall_cnt;
        logic     prev_req;
        logic     prev_we;
        cpu_exp_t ce;
        mem_exp_t me;
        stall_cnt = 0;
        prev_req = 1'b0;
        prev_we = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                stall_cnt = 0;
                prev_req = 1'b0;
                prev_we = 1'b0;
            end else begin
                if (cpu_req_i && cpu_stall_o) begin
                    stall_cnt++;
                end else if (cpu_req_i) begin
                    if (cpu_q.size() == 0) begin
                        check("cpu_q_pending", cpu_q.size(), 1);
                    end else begin
                        ce = cpu_q.pop_front();
                        check("stall_cycles", stall_cnt, ce.stalls);
                        if (!ce.we) check("load_data", cpu_data_o, ce.data);
                    end
                    stall_cnt = 0;
                end else begin
                    stall_cnt = 0;
                end
                if (mem_req_o && (!prev_req || mem_we_o != prev_we)) begin
                    if (mem_q.size() == 0) begin
                        check("mem_q_pending", mem_q.size(), 1);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_we", mem_we_o, me.we);
                        check("mem_addr", mem_addr_o, me.addr);
                        check("mem_req_continuous", prev_req, me.cont);
                        if (me.we) check("wb_data", mem_data_o, me.data);
                    end
                end
                prev_req = mem_req_o;
                prev_we = mem_we_o;
            end
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int i;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        i = 0;
        while (i < 100) begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            i++;
        end
        if (i == 100) check("access_timeout", cpu_stall_o, 0);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i = 1'b0;
    endtask

    initial begin
        int i;
        n_checks = 0;
        n_pass = 0;
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        cpu_we_i = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        force_ack = 1'b0;
        mem_auto = 1'b1;
        ack_delay = 3;
        fork
            monitor();
        join_none

        #1;
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_stall", cpu_stall_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Spurious ack while idle with no request
        @(negedge clk_i) force_ack = 1'b1;
        @(negedge clk_i) force_ack = 1'b0;
        @(negedge clk_i);
        check("idle_ack_stall", cpu_stall_o, 0);
        check("idle_ack_req", mem_req_o, 0);

        // Clean miss, ack on the third request cycle
        exp_mem(1'b0, 32'h0000_0100, '0, 1'b0);
        exp_cpu(1'b0, 32'hDEAD_BEEF, 4);
        access(1'b0, 32'h0000_0104, '0);

        // Store hit, then conflicting load forcing write-back then fill
        exp_cpu(1'b1, '0, 0);
        access(1'b1, 32'h0000_0108, 32'h1234_5678);
        exp_mem(1'b1, 32'h0000_0100, L100_WB, 1'b0);
        exp_mem(1'b0, 32'h0000_0200, '0, 1'b1);
        exp_cpu(1'b0, 32'hCAFE_F00D, 7);
        access(1'b0, 32'h0000_0204, '0);

        // Re-load hits; evicting the clean line needs no write-back
        exp_cpu(1'b0, 32'hCAFE_F00D, 0);
        access(1'b0, 32'h0000_0204, '0);
        exp_mem(1'b0, 32'h0000_0100, '0, 1'b0);
        exp_cpu(1'b0, 32'hDEAD_BEEF, 4);
        access(1'b0, 32'h0000_0104, '0);
        exp_cpu(1'b0, 32'h1234_5678, 0);
        access(1'b0, 32'h0000_0108, '0);

        // Reset during ALLOCATE with the ack withheld, then a late ack
        mem_auto = 1'b0;
        exp_mem(1'b0, 32'h0000_0300, '0, 1'b0);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b1;
        cpu_we_i = 1'b0;
        cpu_addr_i = 32'h0000_0304;
        i = 0;
        while (i < 20 && !mem_req_o) begin
            @(negedge clk_i);
            i++;
        end
        check("alloc_req_up", mem_req_o, 1);
        check("alloc_stall", cpu_stall_o, 1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        check("rst_drops_req", mem_req_o, 0);
        check("rst_drops_we", mem_we_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i) force_ack = 1'b1;
        @(negedge clk_i) force_ack = 1'b0;
        repeat (2) @(negedge clk_i);
        check("late_ack_req", mem_req_o, 0);
        check("late_ack_stall", cpu_stall_o, 0);

        // Reload misses again; ack in the first request cycle gives a 2-cycle stall
        mem_auto = 1'b1;
        ack_delay = 1;
        exp_mem(1'b0, 32'h0000_0300, '0, 1'b0);
        exp_cpu(1'b0, 32'h3333_0001, 2);
        access(1'b0, 32'h0000_0304, '0);

        repeat (3) @(negedge clk_i);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
